inst_mem_prog: RTL and testbench
================================

INST_MEM_PROG -- requirements
Module: inst_mem_prog

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; DEPTH = 2^ADDR_W bytes.
REQ-002 Parameter INST_BYTES, default 2, bytes per instruction fetch (1..4).
REQ-003 clk  input  1  single clock, all sequential logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc  input  ADDR_W  byte address of fetch.
REQ-006 rd_en  input  1  fetch request.
REQ-007 inst  output  8*INST_BYTES  fetched instruction, registered.
REQ-008 inst_valid  output  1  inst holds a fetch result this cycle.
REQ-009 misalign  output  1  fetch pc not a multiple of INST_BYTES, aligned with inst_valid.
REQ-010 ld_start  input  1  pulse: begin program load at byte 0.
REQ-011 ld_valid  input  1  ld_data holds a byte.
REQ-012 ld_data  input  8  program byte.
REQ-013 ld_last  input  1  final byte of load, qualified by ld_valid.
REQ-014 ld_ready  output  1  block accepts a load byte.
REQ-015 busy  output  1  high in CLEAR or LOAD.
REQ-016 load_done  output  1  one-cycle pulse at end of load.
REQ-017 ld_count  output  ADDR_W+1  bytes written by current/last load.

Function
REQ-018 The block SHALL hold a DEPTH x 8-bit byte array; the array itself SHALL NOT be asynchronously reset.
REQ-019 The FSM SHALL have states CLEAR, IDLE, LOAD.
REQ-020 CLEAR: one byte per cycle written 0x00, addresses 0..DEPTH-1 ascending; after writing DEPTH-1 -> IDLE; clear takes exactly DEPTH cycles.
REQ-021 IDLE: ld_start=1 -> LOAD next cycle, write pointer and ld_count set to 0.
REQ-022 LOAD: ld_ready=1; each cycle with ld_valid&ld_ready writes ld_data at the write pointer, increments pointer and ld_count.
REQ-023 LOAD SHALL exit to IDLE and pulse load_done the cycle after a write with ld_last=1 or a write to address DEPTH-1, whichever comes first; bytes not written keep prior contents.
REQ-024 ld_start SHALL be ignored in CLEAR and LOAD; ld_valid SHALL be ignored outside LOAD.
REQ-025 Fetch: in IDLE, rd_en=1 at edge N SHALL give inst = {mem[pc], mem[pc+1], ..., mem[pc+INST_BYTES-1]} (big-endian, first byte MSB) with inst_valid=1 after edge N (1-cycle latency).
REQ-026 Byte addresses pc+k SHALL wrap modulo DEPTH.
REQ-027 misalign SHALL be (pc mod INST_BYTES != 0) registered with the fetch; data SHALL still be returned.
REQ-028 rd_en while busy SHALL be ignored: inst_valid=0, inst holds last value.
REQ-029 rd_en and ld_start in the same IDLE cycle: fetch SHALL use pre-load contents; LOAD entered next cycle.
REQ-030 inst_valid SHALL be 0 in any cycle without an accepted fetch; inst holds its value.

Reset
REQ-031 rst=1 SHALL immediately force: state CLEAR, clear pointer 0, inst=0, inst_valid=0, misalign=0, ld_ready=0, load_done=0, ld_count=0, busy=1.
REQ-032 rst during LOAD SHALL abort the load and restart CLEAR after release; no further load bytes written.
REQ-033 After rst deasserts, busy SHALL remain 1 for exactly DEPTH cycles.

Verification
REQ-034 Defaults: release rst -> busy=1 for 256 cycles then 0; fetch pc=0x10 -> inst=0x0000, inst_valid next cycle.
REQ-035 Load 0x70,0x00,0xE0,0xFF, ld_last on 4th -> load_done one pulse, ld_count=4; fetch pc=0 -> 0x7000; pc=2 -> 0xE0FF, misalign=0.
REQ-036 Load 256 bytes value=i, no ld_last -> load_done after byte 255, ld_count=256; fetch pc=0xFF -> inst=0xFF00, misalign=1.
REQ-037 rst asserted after 3 load bytes -> ld_ready=0, busy=1 at once; after 256 cycles fetch pc=0 -> 0x0000.
REQ-038 In LOAD, ld_valid low 5 cycles -> no writes, ld_count unchanged; rd_en in LOAD -> inst_valid stays 0.
REQ-039 INST_BYTES=4: after loading 0x11,0x22,0x33,0x44,0x55, fetch pc=1 -> inst=0x22334455, misalign=1.

Source files
------------

// File: rtl/inst_mem_prog.sv
// Byte-wide program memory with a streaming loader and a big-endian multi-byte fetch port.
// After reset the whole array is zeroed one byte per cycle before loads or fetches are accepted.
module inst_mem_prog #(
    parameter int ADDR_W     = 8,
    parameter int INST_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       pc,
    input  logic                    rd_en,
    output logic [8*INST_BYTES-1:0] inst,
    output logic                    inst_valid,
    output logic                    misalign,
    input  logic                    ld_start,
    input  logic                    ld_valid,
    input  logic [7:0]              ld_data,
    input  logic                    ld_last,
    output logic                    ld_ready,
    output logic                    busy,
    output logic                    load_done,
    output logic [ADDR_W:0]         ld_count
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam int                INST_W   = 8 * INST_BYTES;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IB_A     = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    logic [7:0] mem_q [DEPTH];

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   clr_ptr_q,    clr_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W:0]     ld_count_q,   ld_count_d;
    logic [INST_W-1:0]   inst_q,       inst_d;
    logic                inst_valid_q, inst_valid_d;
    logic                misalign_q,   misalign_d;
    logic                load_done_q,  load_done_d;
    logic                ld_ready_q,   ld_ready_d;
    logic                busy_q,       busy_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [7:0]          mem_wdata;
    logic                fetch_ok;
    logic [INST_W-1:0]   fetch_word;
    logic                pc_misaligned;

    // Next-state logic for the clear/idle/load controller and the single memory write port
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        ld_count_d  = ld_count_q;
        load_done_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = clr_ptr_q;
        mem_wdata   = 8'h00;
        fetch_ok    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = 8'h00;
                if (clr_ptr_q == ADDR_MAX) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = {ADDR_W{1'b0}};
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_ONE;
                end
            end
            ST_IDLE: begin
                fetch_ok = rd_en;
                if (ld_start) begin
                    state_d    = ST_LOAD;
                    wr_ptr_d   = {ADDR_W{1'b0}};
                    ld_count_d = {(ADDR_W + 1){1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    mem_we     = 1'b1;
                    mem_waddr  = wr_ptr_q;
                    mem_wdata  = ld_data;
                    wr_ptr_d   = wr_ptr_q + ADDR_ONE;
                    ld_count_d = ld_count_q + CNT_ONE;
                    // Top address ends the load even without ld_last so the pointer never wraps
                    if (ld_last || (wr_ptr_q == ADDR_MAX)) begin
                        state_d     = ST_IDLE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = {ADDR_W{1'b0}};
            end
        endcase
        ld_ready_d = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_IDLE);
    end

    // Gather INST_BYTES consecutive bytes, first byte in the MSBs, addresses wrapping at the top
    always_comb begin
        fetch_word = {INST_W{1'b0}};
        for (int k = 0; k < INST_BYTES; k++) begin
            fetch_word[8*(INST_BYTES-1-k) +: 8] = mem_q[pc + ADDR_W'(k)];
        end
        pc_misaligned = ((pc % IB_A) != {ADDR_W{1'b0}});
    end

    // Fetch result register: updates only on an accepted fetch, otherwise holds
    always_comb begin
        inst_valid_d = fetch_ok;
        if (fetch_ok) begin
            inst_d     = fetch_word;
            misalign_d = pc_misaligned;
        end else begin
            inst_d     = inst_q;
            misalign_d = 1'b0;
        end
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= {ADDR_W{1'b0}};
            wr_ptr_q     <= {ADDR_W{1'b0}};
            ld_count_q   <= {(ADDR_W + 1){1'b0}};
            inst_q       <= {INST_W{1'b0}};
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            load_done_q  <= 1'b0;
            ld_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            ld_count_q   <= ld_count_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
            load_done_q  <= load_done_d;
            ld_ready_q   <= ld_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Byte array write port; contents are deliberately not reset (CLEAR zeroes them)
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign misalign   = misalign_q;
    assign load_done  = load_done_q;
    assign ld_ready   = ld_ready_q;
    assign busy       = busy_q;
    assign ld_count   = ld_count_q;

endmodule

// File: tb/tb_inst_mem_prog.sv
// Directed bench: a 2-byte and a 4-byte fetch instance share all inputs; expected values are hand-computed.
module tb_inst_mem_prog;

    logic        clk;
    logic        rst;
    logic [7:0]  pc;
    logic        rd_en;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;

    logic [15:0] inst;
    logic        inst_valid, misalign, ld_ready, busy, load_done;
    logic [8:0]  ld_count;

    logic [31:0] inst4;
    logic        inst_valid4, misalign4, ld_ready4, busy4, load_done4;
    logic [8:0]  ld_count4;

    int n_checks;
    int n_pass;
    int cyc;

    inst_mem_prog #(.ADDR_W(8), .INST_BYTES(2)) u_dut (
        .clk(clk), .rst(rst), .pc(pc), .rd_en(rd_en),
        .inst(inst), .inst_valid(inst_valid), .misalign(misalign),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .busy(busy), .load_done(load_done), .ld_count(ld_count)
    );

    inst_mem_prog #(.ADDR_W(8), .INST_BYTES(4)) u_dut4 (
        .clk(clk), .rst(rst), .pc(pc), .rd_en(rd_en),
        .inst(inst4), .inst_valid(inst_valid4), .misalign(misalign4),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready4), .busy(busy4), .load_done(load_done4), .ld_count(ld_count4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a);
        pc    = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (busy && cyc < 400);
        check(tag, 64'(cyc), 64'd256);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; pc = 8'h00; rd_en = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        n_checks = 0; n_pass = 0;

        tick(); tick();
        check("rst_busy",       64'(busy),       64'd1);
        check("rst_ld_ready",   64'(ld_ready),   64'd0);
        check("rst_inst",       64'(inst),       64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_load_done",  64'(load_done),  64'd0);
        check("rst_ld_count",   64'(ld_count),   64'd0);
        check("rst_misalign",   64'(misalign),   64'd0);

        rst = 1'b0;
        wait_clear("clear_len");

        fetch(8'h10);
        check("f10_inst",  64'(inst),       64'h0000);
        check("f10_valid", 64'(inst_valid), 64'd1);
        tick();
        check("idle_valid_low", 64'(inst_valid), 64'd0);

        // Load 70 00 E0 FF with a 5-cycle stall after byte 2
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("ld_ready_on", 64'(ld_ready), 64'd1);
        check("ld_busy_on",  64'(busy),     64'd1);
        check("ld_cnt0",     64'(ld_count), 64'd0);
        load_byte(8'h70, 1'b0);
        load_byte(8'h00, 1'b0);
        rd_en    = 1'b1;
        ld_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_cnt",   64'(ld_count),   64'd2);
            check("stall_valid", 64'(inst_valid), 64'd0);
        end
        rd_en    = 1'b0;
        ld_start = 1'b0;
        load_byte(8'hE0, 1'b0);
        check("pre_done", 64'(load_done), 64'd0);
        load_byte(8'hFF, 1'b1);
        check("done_pulse", 64'(load_done), 64'd1);
        check("done_cnt",   64'(ld_count),  64'd4);
        check("done_busy",  64'(busy),      64'd0);
        check("done_ready", 64'(ld_ready),  64'd0);
        tick();
        check("done_once",  64'(load_done), 64'd0);

        fetch(8'h00);
        check("f0_inst",  64'(inst),      64'h7000);
        check("f0_mis",   64'(misalign),  64'd0);
        check("f0_inst4", 64'(inst4),     64'h7000E0FF);
        fetch(8'h02);
        check("f2_inst",  64'(inst),      64'hE0FF);
        check("f2_mis",   64'(misalign),  64'd0);
        check("f2_inst4", 64'(inst4),     64'hE0FF0000);
        check("f2_mis4",  64'(misalign4), 64'd1);
        fetch(8'h01);
        check("f1_inst",  64'(inst),      64'h00E0);
        check("f1_mis",   64'(misalign),  64'd1);
        tick();
        check("hold_inst", 64'(inst), 64'h00E0);

        // Fetch and ld_start together: fetch sees pre-load contents
        pc = 8'h00; rd_en = 1'b1; ld_start = 1'b1;
        tick();
        rd_en = 1'b0; ld_start = 1'b0;
        check("sim_inst",  64'(inst),     64'h7000);
        check("sim_inst4", 64'(inst4),    64'h7000E0FF);
        check("sim_ready", 64'(ld_ready), 64'd1);
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        load_byte(8'h33, 1'b0);
        load_byte(8'h44, 1'b0);
        load_byte(8'h55, 1'b1);
        check("ld5_cnt", 64'(ld_count), 64'd5);
        fetch(8'h01);
        check("p1_inst4", 64'(inst4),     64'h22334455);
        check("p1_mis4",  64'(misalign4), 64'd1);
        check("p1_inst",  64'(inst),      64'h2233);
        fetch(8'h04);
        check("p4_inst",  64'(inst),      64'h5500);
        check("p4_mis4",  64'(misalign4), 64'd0);

        // Full 256-byte load without ld_last, then a stray byte that must be ignored
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            load_byte(8'(i), 1'b0);
            if (i == 254) check("full_pre_done", 64'(load_done), 64'd0);
        end
        check("full_done", 64'(load_done), 64'd1);
        check("full_cnt",  64'(ld_count),  64'd256);
        load_byte(8'hAA, 1'b0);
        check("full_cnt_hold", 64'(ld_count), 64'd256);
        fetch(8'hFF);
        check("ff_inst",  64'(inst),      64'hFF00);
        check("ff_mis",   64'(misalign),  64'd1);
        check("ff_inst4", 64'(inst4),     64'hFF000102);
        fetch(8'h00);
        check("z_inst",   64'(inst),      64'h0001);
        fetch(8'h80);
        check("80_inst4", 64'(inst4),     64'h80818283);
        check("80_mis4",  64'(misalign4), 64'd0);

        // Reset in the middle of a load
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        load_byte(8'hA1, 1'b0);
        load_byte(8'hA2, 1'b0);
        load_byte(8'hA3, 1'b0);
        ld_valid = 1'b1; ld_data = 8'hBB;
        rst = 1'b1;
        #1;
        check("ar_ready", 64'(ld_ready), 64'd0);
        check("ar_busy",  64'(busy),     64'd1);
        check("ar_cnt",   64'(ld_count), 64'd0);
        check("ar_inst",  64'(inst),     64'd0);
        tick(); tick();
        rst = 1'b0;
        wait_clear("clear_len2");
        ld_valid = 1'b0;
        fetch(8'h00);
        check("ar_f0",  64'(inst),  64'h0000);
        check("ar_f04", 64'(inst4), 64'h00000000);
        check("ar_fv",  64'(inst_valid), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
